// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned OPW_DEF   = 3;

   localparam int unsigned REQ0 = 0;
   localparam int unsigned REQ1 = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins, a tie goes to ptr_i.
module rr_arb2
   import alu_share_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_oh_o,
   output logic       gnt_idx_o
);

   always_comb begin
      gnt_idx_o = 1'(REQ0);
      gnt_oh_o  = 2'b00;
      unique case (valid_i)
         2'b01:   gnt_idx_o = 1'(REQ0);
         2'b10:   gnt_idx_o = 1'(REQ1);
         2'b11:   gnt_idx_o = ptr_i;
         default: gnt_idx_o = 1'(REQ0);
      endcase
      if (valid_i != 2'b00) begin
         gnt_oh_o = gnt_idx_o ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// Optional per-requester grant counters: define ALU_SHARE_CTRL_GRANT_CNT_EN.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned OPW   = OPW_DEF,
   parameter int unsigned CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*WIDTH-1:0]    req_a,
   input  logic [2*WIDTH-1:0]    req_b,
   input  logic [2*OPW-1:0]      req_op,
   output logic [1:0]            resp_valid,
   input  logic [1:0]            resp_ready,
   output logic [WIDTH-1:0]      resp_data,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [OPW-1:0]        alu_op,
   input  logic [WIDTH-1:0]      alu_out,
   output logic                  busy,
   output logic [2*CNTW-1:0]     grant_cnt
);

   state_e             state_q, state_d;
   logic               rr_q, rr_d;
   logic               gnt_q, gnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [OPW-1:0]     op_q, op_d;
   logic [1:0]         arb_oh;
   logic               arb_idx;
   logic               accept;
   logic               done;

   rr_arb2 u_arb (
      .valid_i   (req_valid),
      .ptr_i     (rr_q),
      .gnt_oh_o  (arb_oh),
      .gnt_idx_o (arb_idx)
   );

   // The granted requester's ready mirrors its valid, so any valid in IDLE is a handshake.
   assign accept = (state_q == IDLE) && (req_valid != 2'b00);
   assign done   = (state_q == RESP) && resp_ready[gnt_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      if (state_q == IDLE) req_ready = arb_oh;
      if (state_q == RESP) resp_valid = gnt_q ? 2'b10 : 2'b01;
      busy      = (state_q != IDLE);
      resp_data = res_q;
      alu_a     = a_q;
      alu_b     = b_q;
      alu_op    = op_q;
   end

   // Operands only load on a handshake, so requester-side toggling never reaches the ALU.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      gnt_d = gnt_q;
      res_d = res_q;
      rr_d  = rr_q;
      if (accept) begin
         gnt_d = arb_idx;
         a_d   = arb_idx ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
         b_d   = arb_idx ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
         op_d  = arb_idx ? req_op[OPW +: OPW]    : req_op[0 +: OPW];
      end
      if (state_q == EXEC) res_d = alu_out;
      if (done) rr_d = ~gnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         gnt_q <= 1'b0;
         res_q <= '0;
         rr_q  <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         gnt_q <= gnt_d;
         res_q <= res_d;
         rr_q  <= rr_d;
      end
   end

`ifdef ALU_SHARE_CTRL_GRANT_CNT_EN
   logic [1:0][CNTW-1:0] cnt_q, cnt_d;

   // Saturating per-requester handshake counters.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (accept && (arb_idx == 1'(i)) && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`else
   assign grant_cnt = '0;
`endif

endmodule
